// File: rtl/dmem_port_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module   : dmem_port_arbiter_pkg
// Brief    : Shared owner encoding, DMEM region decode and defaults for the
//            DMEM port arbiter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    // DMEM region is cpu_addr[31:28] == 4'b00X1 (0x1xxx_xxxx or 0x3xxx_xxxx)
    localparam logic [3:0] C_DMEM_REGION_MASK = 4'b1101;
    localparam logic [3:0] C_DMEM_REGION_VAL  = 4'b0001;

    localparam int C_DEFAULT_STARVE_LIMIT = 8;

    function automatic logic is_dmem_addr(input logic [31:0] addr);
        return (addr[31:28] & C_DMEM_REGION_MASK) == C_DMEM_REGION_VAL;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_port_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : dmem_port_arbiter_if
// Brief    : CPU, DMA and DMEM-side signals of the DMEM port arbiter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface dmem_port_arbiter_if #(
    parameter int AWIDTH = 14,
    parameter int DWIDTH = 32
);
    logic              cpu_req;
    logic [31:0]       cpu_addr;
    logic [3:0]        cpu_we;
    logic [DWIDTH-1:0] cpu_din;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DWIDTH-1:0] cpu_dout;

    logic              dma_req;
    logic [AWIDTH-1:0] dma_addr;
    logic [3:0]        dma_we;
    logic [DWIDTH-1:0] dma_din;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DWIDTH-1:0] dma_dout;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_din;
    logic [DWIDTH-1:0] mem_dout;

    modport slave (
        input  cpu_req, cpu_addr, cpu_we, cpu_din,
        output cpu_stall, cpu_rvalid, cpu_dout,
        input  dma_req, dma_addr, dma_we, dma_din,
        output dma_gnt, dma_rvalid, dma_dout,
        output mem_en, mem_we, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output cpu_req, cpu_addr, cpu_we, cpu_din,
        input  cpu_stall, cpu_rvalid, cpu_dout,
        output dma_req, dma_addr, dma_we, dma_din,
        input  dma_gnt, dma_rvalid, dma_dout,
        input  mem_en, mem_we, mem_addr, mem_din,
        output mem_dout
    );

endinterface

`default_nettype wire

// File: rtl/dmem_arb_starve_counter.sv
//------------------------------------------------------------------------------
// Module   : dmem_arb_starve_counter
// Brief    : Counts consecutive denied DMA cycles, saturating at STARVE_LIMIT,
//            and raises force_o once the limit is reached.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_arb_starve_counter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = C_DEFAULT_STARVE_LIMIT
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic dma_req_i,
    input  wire logic dma_gnt_i,
    output logic      force_o
);

    localparam int              C_CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [C_CW-1:0] C_LIMIT = C_CW'(STARVE_LIMIT);

    logic [C_CW-1:0] cnt_q;
    logic [C_CW-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (dma_req_i && !dma_gnt_i) begin
            cnt_d = (cnt_q == C_LIMIT) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_o = dma_req_i && (cnt_q == C_LIMIT);

endmodule

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : dmem_port_arbiter
// Brief    : Shares the single-port DMEM between the CPU memory stage (fixed
//            priority) and a DMA engine (starvation-bounded), tagging read
//            data back to its issuer. DMEM_ARB_STATS_EN adds stall/grant
//            cycle counters.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int AWIDTH       = 14,
    parameter int DWIDTH       = 32,
    parameter int STARVE_LIMIT = C_DEFAULT_STARVE_LIMIT
) (
    input  wire logic          clk,
    input  wire logic          rst,
    dmem_port_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]        stat_cpu_stall,
    output logic [31:0]        stat_dma_gnt
`endif
);

    logic   w_cpu_hit;
    logic   w_force_dma;
    logic   w_unused_addr;
    owner_e w_owner;
    owner_e rd_owner_q;
    owner_e rd_owner_d;

    assign w_cpu_hit     = bus.cpu_req && is_dmem_addr(bus.cpu_addr);
    assign w_unused_addr = ^bus.cpu_addr;

    dmem_arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .dma_req_i (bus.dma_req),
        .dma_gnt_i (bus.dma_gnt),
        .force_o   (w_force_dma)
    );

    // Owner is forced to NONE during reset so every combinational output is 0.
    always_comb begin
        w_owner = OWN_NONE;
        if (rst) begin
            w_owner = OWN_NONE;
        end else if (w_force_dma) begin
            w_owner = OWN_DMA;
        end else if (w_cpu_hit) begin
            w_owner = OWN_CPU;
        end else if (bus.dma_req) begin
            w_owner = OWN_DMA;
        end
    end

    always_comb begin
        bus.mem_we   = '0;
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        case (w_owner)
            OWN_CPU: begin
                bus.mem_we   = bus.cpu_we;
                bus.mem_addr = bus.cpu_addr[AWIDTH+1:2];
                bus.mem_din  = bus.cpu_din;
            end
            OWN_DMA: begin
                bus.mem_we   = bus.dma_we;
                bus.mem_addr = bus.dma_addr;
                bus.mem_din  = bus.dma_din;
            end
            default: ;
        endcase
    end

    assign bus.mem_en    = (w_owner != OWN_NONE);
    assign bus.dma_gnt   = (w_owner == OWN_DMA);
    assign bus.cpu_stall = !rst && w_force_dma && w_cpu_hit;

    assign rd_owner_d = (bus.mem_en && (bus.mem_we == 4'b0000)) ? w_owner : OWN_NONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_owner_q <= OWN_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    assign bus.cpu_rvalid = (rd_owner_q == OWN_CPU);
    assign bus.dma_rvalid = (rd_owner_q == OWN_DMA);
    assign bus.cpu_dout   = bus.cpu_rvalid ? bus.mem_dout : '0;
    assign bus.dma_dout   = bus.dma_rvalid ? bus.mem_dout : '0;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_cpu_stall_q;
    logic [31:0] stat_dma_gnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cpu_stall_q <= '0;
            stat_dma_gnt_q   <= '0;
        end else begin
            stat_cpu_stall_q <= stat_cpu_stall_q + {31'd0, bus.cpu_stall};
            stat_dma_gnt_q   <= stat_dma_gnt_q + {31'd0, bus.dma_gnt};
        end
    end

    assign stat_cpu_stall = stat_cpu_stall_q;
    assign stat_dma_gnt   = stat_dma_gnt_q;
`endif

endmodule

`default_nettype wire

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port synchronous data memory (DMEM) between two requesters:
  - the CPU memory stage (loads and stores);
  - a streaming DMA engine, e.g. mic FIFO to DMEM capture.
- The CPU has fixed priority, bounded by a starvation counter so DMA is guaranteed forward progress.
- Sits between the CPU memory stage and the DMEM macro.
- Returns read data to the owner that issued the read, so the load-formatting logic downstream sees correctly tagged data.

Parameters:
- AWIDTH, 14, DMEM word-address width.
- DWIDTH, 32, data width.
- STARVE_LIMIT, 8, consecutive cycles DMA may be denied before it is forced a grant; must be at least 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- cpu_req  input  1  CPU memory access this cycle.
- cpu_addr  input  32  CPU byte address.
- cpu_we  input  4  CPU byte write enables; 0 means read.
- cpu_din  input  32  CPU write data.
- cpu_stall  output  1  CPU access not accepted this cycle; CPU holds its request.
- cpu_rvalid  output  1  cpu_dout valid; one cycle after an accepted CPU read.
- cpu_dout  output  32  CPU read data.
- dma_req  input  1  DMA access request.
- dma_addr  input  AWIDTH  DMA word address.
- dma_we  input  4  DMA byte write enables.
- dma_din  input  32  DMA write data.
- dma_gnt  output  1  DMA access accepted this cycle.
- dma_rvalid  output  1  dma_dout valid; one cycle after a granted DMA read.
- dma_dout  output  32  DMA read data.
- mem_en  output  1  DMEM enable.
- mem_we  output  4  DMEM byte write enables.
- mem_addr  output  AWIDTH  DMEM word address.
- mem_din  output  32  DMEM write data.
- mem_dout  input  32  DMEM read data, available one cycle after mem_en.

Behaviour:
- Reset (asynchronous, rst=1):
  - starve_cnt=0, rd_owner=NONE.
  - cpu_rvalid=0, dma_rvalid=0.
  - All combinational outputs are 0 while rst is asserted.
- CPU hit:
  - cpu_hit = cpu_req and cpu_addr[31:28] matches 4'b00X1.
  - A cpu_req outside the DMEM region is ignored: no stall, no memory access.
- Grant (combinational, same cycle as the request):
  - force_dma = dma_req and (starve_cnt == STARVE_LIMIT).
  - If force_dma: DMA owns the port; cpu_stall = cpu_hit.
  - Else if cpu_hit: CPU owns the port; dma_gnt=0.
  - Else if dma_req: DMA owns the port.
  - Else: idle, mem_en=0.
- Memory drive:
  - mem_addr = owner address; for the CPU this is cpu_addr[AWIDTH+1:2].
  - mem_we and mem_din come from the owner.
  - mem_en=1 whenever there is an owner.
- starve_cnt (registered):
  - Increments when dma_req=1 and dma_gnt=0, saturating at STARVE_LIMIT.
  - Clears to 0 on any dma_gnt, or when dma_req=0.
- Read tagging:
  - rd_owner registers CPU, DMA or NONE each cycle, based on an accepted access with mem_we==0.
  - Writes tag NONE.
  - Next cycle: cpu_rvalid = (rd_owner==CPU), dma_rvalid = (rd_owner==DMA).
- Read data:
  - cpu_dout and dma_dout both equal mem_dout.
  - Each is gated to 0 when its rvalid is 0.
- Latency and throughput:
  - Read latency is 1 cycle.
  - Back-to-back accesses are allowed every cycle with no bubble.
  - A forced DMA grant costs the CPU exactly 1 stall cycle, after which starve_cnt=0.
- Simultaneous events:
  - CPU read and DMA write in the same cycle: the CPU wins unless force_dma.
  - Owner changing between consecutive cycles is legal; tags keep the returned data separated.
- Reset mid-read: any pending rvalid is dropped and that data is lost. Requesters must reissue.

Optional Feature:
DMEM_ARB_STATS_EN
- Defined:
  - Adds output ports stat_cpu_stall (32 bits) and stat_dma_gnt (32 bits).
  - These are free-running wrap-around counters of cycles with cpu_stall=1 and cycles with dma_gnt=1.
  - Both reset to 0 on rst and are readable via the IO map.
- Undefined: ports and counters are absent, with zero area cost.

Decomposition:
- Shared package holds:
  - owner encoding: NONE=2'd0, CPU=2'd1, DMA=2'd2;
  - DMEM region constant 4'b00X1;
  - default STARVE_LIMIT.
- One natural sub-module: dmem_arb_starve_counter, the saturating counter with force flag.

Test Plan:
- Reset: assert rst mid-cycle with cpu_req=1 -> all outputs 0 immediately; after release, starve_cnt=0 and no rvalid.
- CPU read at 0x1000_0008 with mem_dout=0xDEADBEEF -> mem_addr=2, no stall; next cycle cpu_rvalid=1, cpu_dout=0xDEADBEEF, dma_rvalid=0.
- CPU read at 0x8000_0000 (IO space) with dma_req=1 -> dma_gnt=1, cpu_stall=0, mem_addr=dma_addr.
- Continuous cpu_hit and dma_req with STARVE_LIMIT=8 -> dma_gnt=0 for 8 cycles; cycle 9: dma_gnt=1, cpu_stall=1; cycle 10: CPU regains the port.
- Alternate CPU read and DMA read every cycle -> rvalid tags alternate correctly; each dout matches its own address data.
- DMA write with dma_we=4'b0011 and cpu_req=0 -> mem_we=0011, dma_gnt=1, no rvalid next cycle.
